// File: rtl/calc_sequencer.sv
// Calculator control sequencer: debounced-edge Enter/Cancel handling,
// operand load strobes, op select and chained-result feedback.
module calc_sequencer (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [7:0] Sw,
    input  logic       Enter,
    input  logic       Cancel,
    input  logic       SubSel,
    input  logic       Chain,
    input  logic [7:0] Result,
    output logic [7:0] X,
    output logic       InA,
    output logic       InB,
    output logic       Out,
    output logic       Clear,
    output logic       Add_Subtract,
    output logic [1:0] Phase,
    output logic       Busy
);

    typedef enum logic [2:0] {
        S_CLR,
        S_WAIT_A,
        S_LOAD_A,
        S_WAIT_B,
        S_LOAD_B,
        S_EXEC,
        S_SHOW
    } state_t;

    state_t state_q, state_d;
    logic   op_q, op_d;
    logic   chain_q, chain_d;

    logic ent_s1_q, ent_s1_d;
    logic ent_s2_q, ent_s2_d;
    logic ent_prev_q, ent_prev_d;
    logic can_s1_q, can_s1_d;
    logic can_s2_q, can_s2_d;
    logic can_prev_q, can_prev_d;

    logic enter_pls;
    logic cancel_pls;

    always_comb begin
        ent_s1_d   = Enter;
        ent_s2_d   = ent_s1_q;
        ent_prev_d = ent_s2_q;
        can_s1_d   = Cancel;
        can_s2_d   = can_s1_q;
        can_prev_d = can_s2_q;
    end

    assign enter_pls  = ent_s2_q & ~ent_prev_q;
    assign cancel_pls = can_s2_q & ~can_prev_q;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= S_CLR;
            op_q       <= 1'b0;
            chain_q    <= 1'b0;
            ent_s1_q   <= 1'b0;
            ent_s2_q   <= 1'b0;
            ent_prev_q <= 1'b0;
            can_s1_q   <= 1'b0;
            can_s2_q   <= 1'b0;
            can_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            chain_q    <= chain_d;
            ent_s1_q   <= ent_s1_d;
            ent_s2_q   <= ent_s2_d;
            ent_prev_q <= ent_prev_d;
            can_s1_q   <= can_s1_d;
            can_s2_q   <= can_s2_d;
            can_prev_q <= can_prev_d;
        end
    end

    // Enter pulses in states without an Enter arc are simply dropped
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        chain_d = chain_q;
        unique case (state_q)
            S_CLR: begin
                state_d = S_WAIT_A;
                op_d    = 1'b0;
                chain_d = 1'b0;
            end
            S_WAIT_A: begin
                if (enter_pls) begin
                    state_d = S_LOAD_A;
                    chain_d = 1'b0;
                end
            end
            S_LOAD_A: state_d = S_WAIT_B;
            S_WAIT_B: begin
                if (enter_pls) begin
                    state_d = S_LOAD_B;
                    op_d    = SubSel;
                end
            end
            S_LOAD_B: state_d = S_EXEC;
            S_EXEC:   state_d = S_SHOW;
            S_SHOW: begin
                if (enter_pls) begin
                    state_d = S_LOAD_A;
                    chain_d = Chain;
                end
            end
            default: state_d = S_CLR;
        endcase
        if (cancel_pls) begin
            state_d = S_CLR;
            op_d    = 1'b0;
            chain_d = 1'b0;
        end
    end

    always_comb begin
        Clear        = (state_q == S_CLR);
        InA          = (state_q == S_LOAD_A);
        InB          = (state_q == S_LOAD_B);
        Out          = (state_q == S_EXEC);
        Add_Subtract = op_q;
        X            = Sw;
        if (state_q == S_LOAD_A && chain_q) begin
            X = Result;
        end
        Phase = 2'b11;
        Busy  = 1'b1;
        unique case (state_q)
            S_WAIT_A: begin
                Phase = 2'b00;
                Busy  = 1'b0;
            end
            S_WAIT_B: begin
                Phase = 2'b01;
                Busy  = 1'b0;
            end
            S_SHOW: begin
                Phase = 2'b10;
                Busy  = 1'b0;
            end
            default: begin
                Phase = 2'b11;
                Busy  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a small arithmetic-unit model
// closing the Result feedback loop.
module tb_calc_sequencer;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic [7:0] Sw;
    logic       Enter;
    logic       Cancel;
    logic       SubSel;
    logic       Chain;
    logic [7:0] Result;
    logic [7:0] X;
    logic       InA;
    logic       InB;
    logic       Out;
    logic       Clear;
    logic       Add_Subtract;
    logic [1:0] Phase;
    logic       Busy;

    calc_sequencer dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .Sw          (Sw),
        .Enter       (Enter),
        .Cancel      (Cancel),
        .SubSel      (SubSel),
        .Chain       (Chain),
        .Result      (Result),
        .X           (X),
        .InA         (InA),
        .InB         (InB),
        .Out         (Out),
        .Clear       (Clear),
        .Add_Subtract(Add_Subtract),
        .Phase       (Phase),
        .Busy        (Busy)
    );

    always #5 Clock = ~Clock;

    // arithmetic unit model
    logic [7:0] a_q = 8'h00;
    logic [7:0] b_q = 8'h00;
    logic [7:0] res_q = 8'h00;
    assign Result = Add_Subtract ? (a_q - b_q) : (a_q + b_q);

    always @(posedge Clock) begin
        if (Clear) begin
            a_q   <= 8'h00;
            b_q   <= 8'h00;
            res_q <= 8'h00;
        end else begin
            if (InA) a_q <= X;
            if (InB) b_q <= X;
            if (Out) res_q <= Result;
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    int ina_cnt = 0;
    int inb_cnt = 0;
    int out_cnt = 0;
    int clr_cnt = 0;
    int overlap_cnt = 0;
    logic [7:0] x_at_ina = 8'h00;
    logic       as_at_inb = 1'b0;

    always @(posedge Clock) begin
        if (Resetn) begin
            ina_cnt <= ina_cnt + int'(InA);
            inb_cnt <= inb_cnt + int'(InB);
            out_cnt <= out_cnt + int'(Out);
            clr_cnt <= clr_cnt + int'(Clear);
            if (int'(InA) + int'(InB) + int'(Out) + int'(Clear) > 1)
                overlap_cnt <= overlap_cnt + 1;
        end
        if (InA) x_at_ina <= X;
        if (InB) as_at_inb <= Add_Subtract;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic e, input logic c);
        Enter  = e;
        Cancel = c;
        repeat (3) @(negedge Clock);
        Enter  = 1'b0;
        Cancel = 1'b0;
        repeat (4) @(negedge Clock);
    endtask

    int ina0, inb0, out0, clr0;
    logic found;

    initial begin
        Resetn = 1'b0;
        Sw     = 8'h05;
        Enter  = 1'b0;
        Cancel = 1'b0;
        SubSel = 1'b0;
        Chain  = 1'b0;
        repeat (3) @(negedge Clock);
        chk("rst_clear", 32'(Clear), 1);
        chk("rst_strobes", 32'({InA, InB, Out}), 0);
        chk("rst_addsub", 32'(Add_Subtract), 0);
        chk("rst_x", 32'(X), 32'h05);
        chk("rst_phase", 32'(Phase), 3);
        chk("rst_busy", 32'(Busy), 1);
        Resetn = 1'b1;
        #1 chk("rst_clear_hold", 32'(Clear), 1);
        @(negedge Clock);
        chk("post_rst_clear", 32'(Clear), 0);
        chk("post_rst_phase", 32'(Phase), 0);
        chk("post_rst_busy", 32'(Busy), 0);

        // 5 + 3
        ina0 = ina_cnt; inb0 = inb_cnt; out0 = out_cnt;
        Sw = 8'h05;
        press(1'b1, 1'b0);
        chk("a_phase", 32'(Phase), 1);
        Sw = 8'h03; SubSel = 1'b0;
        press(1'b1, 1'b0);
        chk("add_ina", 32'(ina_cnt - ina0), 1);
        chk("add_inb", 32'(inb_cnt - inb0), 1);
        chk("add_out", 32'(out_cnt - out0), 1);
        chk("add_res", 32'(res_q), 32'h08);
        chk("add_phase", 32'(Phase), 2);

        // 3 - 5, unchained from SHOW
        Sw = 8'h03; Chain = 1'b0;
        press(1'b1, 1'b0);
        chk("sub_xa", 32'(x_at_ina), 32'h03);
        Sw = 8'h05; SubSel = 1'b1;
        press(1'b1, 1'b0);
        chk("sub_as_at_inb", 32'(as_at_inb), 1);
        chk("sub_res", 32'(res_q), 32'hFE);
        chk("sub_addsub", 32'(Add_Subtract), 1);

        // rebuild result 8, then chain 8 - 2
        Sw = 8'h05;
        press(1'b1, 1'b0);
        Sw = 8'h03; SubSel = 1'b0;
        press(1'b1, 1'b0);
        chk("pre_chain_res", 32'(res_q), 32'h08);
        Sw = 8'h77; Chain = 1'b1;
        press(1'b1, 1'b0);
        chk("chain_xa", 32'(x_at_ina), 32'h08);
        Chain = 1'b0; Sw = 8'h02; SubSel = 1'b1;
        press(1'b1, 1'b0);
        chk("chain_res", 32'(res_q), 32'h06);

        // held Enter
        press(1'b0, 1'b1);
        chk("cancel_phase", 32'(Phase), 0);
        chk("cancel_addsub", 32'(Add_Subtract), 0);
        ina0 = ina_cnt;
        Sw = 8'h11;
        Enter = 1'b1;
        repeat (50) @(negedge Clock);
        chk("hold_ina", 32'(ina_cnt - ina0), 1);
        chk("hold_phase", 32'(Phase), 1);
        Enter = 1'b0;
        repeat (4) @(negedge Clock);

        // simultaneous Enter + Cancel in WAIT_B
        clr0 = clr_cnt; inb0 = inb_cnt;
        press(1'b1, 1'b1);
        chk("both_clear", 32'(clr_cnt - clr0), 1);
        chk("both_inb", 32'(inb_cnt - inb0), 0);
        chk("both_phase", 32'(Phase), 0);

        // reset during EXEC
        Sw = 8'h01; SubSel = 1'b0;
        press(1'b1, 1'b0);
        out0 = out_cnt;
        Enter = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            if (Out) begin
                found = 1'b1;
                break;
            end
        end
        chk("exec_seen", 32'(found), 1);
        Resetn = 1'b0;
        Enter  = 1'b0;
        #1;
        chk("mid_rst_out", 32'(Out), 0);
        chk("mid_rst_clear", 32'(Clear), 1);
        chk("mid_rst_phase", 32'(Phase), 3);
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        #1 chk("mid_rst_clear_hold", 32'(Clear), 1);
        @(negedge Clock);
        chk("mid_rst_clear_off", 32'(Clear), 0);
        chk("mid_rst_phase_after", 32'(Phase), 0);
        chk("mid_rst_no_out", 32'(out_cnt - out0), 0);
        chk("mid_rst_res", 32'(res_q), 0);
        repeat (4) @(negedge Clock);
        chk("no_overlap", 32'(overlap_cnt), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Control FSM for the 8-bit calculator arithmetic unit (two operand registers, ripple-carry add/subtract, result/flag output registers). It turns one Enter button, one Cancel button and the operand switches into the correctly timed register-load, operation-select, output-latch and clear strobes. It also supports chained operation, where the previous result is fed back as the next A operand.

## Interface
- No parameters; operand width is fixed at 8.
- Clock  in  1  system clock; all state changes on the rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Sw  in  8  operand switches.
- Enter  in  1  raw active-high push-button; acts once per rising edge.
- Cancel  in  1  raw active-high push-button; acts once per rising edge.
- SubSel  in  1  operation select: 0 add, 1 subtract. Sampled when B is loaded.
- Chain  in  1  sampled with Enter in SHOW: 1 reuses the result as A.
- Result  in  8  combinational add/subtract output of the arithmetic unit.
- X  out  8  operand bus to the A/B registers.
- InA, InB  out  1  A/B register load enables.
- Out  out  1  result/flag register load enable.
- Clear  out  1  clear to all arithmetic-unit registers.
- Add_Subtract  out  1  operation select to the adder/subtractor.
- Phase  out  2  status: 00 waiting A, 01 waiting B, 10 showing result, 11 transient.
- Busy  out  1  high in the transient states.

## Operation
- Enter and Cancel each pass through a 2-flop synchronizer, then a rising-edge detector. The detector produces a one-cycle edge pulse. A held button produces exactly one pulse.
- States: CLR, WAIT_A, LOAD_A, WAIT_B, LOAD_B, EXEC, SHOW.
- Transitions:
  - CLR → WAIT_A (unconditional).
  - WAIT_A + Enter edge → LOAD_A.
  - LOAD_A → WAIT_B.
  - WAIT_B + Enter edge → LOAD_B.
  - LOAD_B → EXEC.
  - EXEC → SHOW.
  - SHOW + Enter edge → LOAD_A. The chain flag is captured as Chain at this moment.
- Cancel edge in any state → CLR. Cancel has priority over a simultaneous Enter edge.
- Enter edges arriving in CLR, LOAD_A, LOAD_B or EXEC are discarded, not queued.
- Outputs, decoded from state:
  - Clear = 1 only in CLR.
  - InA = 1 only in LOAD_A.
  - InB = 1 only in LOAD_B.
  - Out = 1 only in EXEC.
- X = Result in LOAD_A entered with chain flag 1; X = Sw otherwise.
- Op register: captures SubSel in LOAD_B, and is cleared to 0 in CLR. Add_Subtract = op register at all times.
- Chain with Result: Result is combinational from unchanged A/B registers, so it is still valid in LOAD_A.
- Unchained SHOW → LOAD_A: the new A comes from Sw. The displayed result is held until the next EXEC.
- Arithmetic is modulo 256. Carry, overflow and other flags are produced by the arithmetic unit; this block does not inspect them.

## Timing
- Reset (Resetn low):
  - State = CLR, op = 0, synchronizer/edge flops = 0.
  - Outputs: Clear = 1, InA = InB = Out = 0, Add_Subtract = 0, X = Sw, Phase = 11, Busy = 1.
- First edge after Resetn rises: → WAIT_A. Clear is therefore high for the whole reset plus one cycle.
- Enter latency: Enter sampled high at edge k; edge pulse valid in cycle after edge k+1; state changes at edge k+2; load strobe high for exactly one cycle from edge k+2 to edge k+3; target register captures at edge k+3.
- EXEC begins one cycle after LOAD_B. Out is high for exactly that one cycle. The result register captures at the end of EXEC.
- Cancel latency matches Enter: Clear asserts 2 edges after Cancel is first sampled high, for exactly 1 cycle.
- Reset asserted mid-operation (any state): immediate return to the reset values above, no partial strobes.
- Every strobe (InA, InB, Out, Clear) is at most 1 cycle long outside reset. No two strobes are ever high together.

## Test plan
- Reset, Sw=5 + Enter, Sw=3 + SubSel=0 + Enter → InA, InB, Out each pulse once; result register = 8, Phase = 10.
- Sw=3 as A, Sw=5 as B with SubSel=1 → Add_Subtract = 1 from LOAD_B onward; result = 0xFE.
- From SHOW with result 8: Chain=1, Enter, then Sw=2, SubSel=1, Enter → X = 8 during LOAD_A; final result = 6.
- Enter held high for 50 cycles in WAIT_A → exactly one InA pulse; state parks in WAIT_B.
- Enter and Cancel rising on the same cycle in WAIT_B → Clear pulses once, no InB; state = WAIT_A.
- Resetn pulsed low during EXEC → Out drops immediately; Clear is high through reset plus one cycle; Phase = 00 afterward.
